// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: round-robin arbiter that lends one shared up counter to N_REQ requesters.
// A granted requester gets a run from 0 up to its latched length. The run ends with a one-cycle
// done pulse on completion, or a one-cycle abort pulse if the requester drops req during the run.
module counter_run_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] len_i,
  input  logic                   stall_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       abort_o,
  output logic [WIDTH-1:0]       count_o,
  output logic                   busy_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] abort_q, abort_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [IdxW-1:0]  last_q, last_d;   // last granted requester (round-robin pointer)
  logic [IdxW-1:0]  gidx_q, gidx_d;   // index of the requester owning the current run
  logic             busy_q, busy_d;

  logic             win_found;
  logic [IdxW-1:0]  win_idx;

  // Requester index reached by stepping 'off+1' places past 'last', wrapping at N_REQ.
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] last,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(last) + 32'd1 + off;
    s = s % N_REQ;
    return s[IdxW-1:0];
  endfunction

  // Round-robin winner: first requesting index searching upward from last_q+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!win_found && req_i[rr_idx(last_q, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last_q, i);
      end
    end
  end

  // Next-state and next-output logic; done/abort default low so they pulse for one cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    abort_d = '0;
    count_d = count_q;
    len_d   = len_q;
    last_d  = last_q;
    gidx_d  = gidx_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StRun;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          count_d          = '0;
          len_d            = len_i[win_idx*WIDTH +: WIDTH];
          last_d           = win_idx;
          gidx_d           = win_idx;
        end
      end

      StRun: begin
        if (!req_i[gidx_q]) begin
          // Abort takes precedence over both stall and completion.
          state_d         = StIdle;
          grant_d         = '0;
          abort_d[gidx_q] = 1'b1;
        end else if (stall_i) begin
          count_d = count_q;
        end else if (count_q == len_q) begin
          state_d        = StDone;
          grant_d        = '0;
          done_d[gidx_q] = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end

      StDone: begin
        // Single settle cycle; requests are ignored here.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset leaves requester 0 at highest priority.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      done_q  <= '0;
      abort_q <= '0;
      count_q <= '0;
      len_q   <= '0;
      last_q  <= IdxW'(N_REQ - 1);
      gidx_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      count_q <= count_d;
      len_q   <= len_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      busy_q  <= busy_d;
    end
  end

  assign grant_o = grant_q;
  assign done_o  = done_q;
  assign abort_o = abort_q;
  assign count_o = count_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed bench for counter_run_arbiter (N_REQ=4, WIDTH=8) with a per-cycle scoreboard.
module tb_counter_run_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] len;
  logic        stall;
  logic [3:0]  grant, done, abort;
  logic [7:0]  count;
  logic        busy;

  counter_run_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .req_i   (req),
    .len_i   (len),
    .stall_i (stall),
    .grant_o (grant),
    .done_o  (done),
    .abort_o (abort),
    .count_o (count),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic [3:0] a;
    logic [7:0] c;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input logic [3:0] g, input logic [3:0] d, input logic [3:0] a,
                      input logic [7:0] c, input logic b);
    exp_t e;
    e.g = g; e.d = d; e.a = a; e.c = c; e.b = b;
    exp_q.push_back(e);
  endtask

  // Expected cycles of a full stall-free run: grant for len+1 cycles, then done.
  task automatic push_run(input logic [3:0] g, input int unsigned l);
    for (int unsigned i = 0; i <= l; i++) push(g, 4'b0, 4'b0, 8'(i), 1'b1);
    push(4'b0, g, 4'b0, 8'(l), 1'b1);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
    end
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      cmp(tag, "grant", {4'b0, grant}, {4'b0, e.g});
      cmp(tag, "done",  {4'b0, done},  {4'b0, e.d});
      cmp(tag, "abort", {4'b0, abort}, {4'b0, e.a});
      cmp(tag, "count", count, e.c);
      cmp(tag, "busy",  {7'b0, busy},  {7'b0, e.b});
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #2;
    check_front(tag);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    len   = '0;
    stall = 1'b0;

    // Reset state
    push(4'b0, 4'b0, 4'b0, 8'd0, 1'b0);
    step("reset");
    #1 reset = 1'b0;

    // Single run, len0=3
    req = 4'b0001; len[7:0] = 8'd3;
    push_run(4'b0001, 3);
    drain("single");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd3, 1'b0);
    step("single_idle");

    // Contention, each requester drops after its done
    req = 4'b0101; len[7:0] = 8'd1; len[23:16] = 8'd2;
    do_reset();
    push_run(4'b0001, 1);
    drain("cont_a");
    req = 4'b0100;
    push(4'b0, 4'b0, 4'b0, 8'd1, 1'b0);
    step("cont_gap");
    push_run(4'b0100, 2);
    drain("cont_b");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd2, 1'b0);
    step("cont_end");

    // Contention with both held: 0, 2, 0, 2
    req = 4'b0101;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      push_run(4'b0001, 1);
      push(4'b0, 4'b0, 4'b0, 8'd1, 1'b0);
      push_run(4'b0100, 2);
      if (k == 0) push(4'b0, 4'b0, 4'b0, 8'd2, 1'b0);
    end
    drain("rr_held");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd2, 1'b0);
    step("rr_end");

    // Abort mid-run at count=2
    req = 4'b0010; len[15:8] = 8'd10;
    for (int i = 0; i < 3; i++) push(4'b0010, 4'b0, 4'b0, 8'(i), 1'b1);
    drain("abort_run");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0010, 8'd2, 1'b0);
    push(4'b0, 4'b0, 4'b0, 8'd2, 1'b0);
    drain("abort");

    // Abort in the completion cycle beats done
    req = 4'b0010; len[15:8] = 8'd2;
    for (int i = 0; i < 3; i++) push(4'b0010, 4'b0, 4'b0, 8'(i), 1'b1);
    drain("abort_last_run");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0010, 8'd2, 1'b0);
    push(4'b0, 4'b0, 4'b0, 8'd2, 1'b0);
    drain("abort_last");

    // Stall two cycles at count=1; len change mid-run is ignored
    req = 4'b0001; len[7:0] = 8'd5;
    push(4'b0001, 4'b0, 4'b0, 8'd0, 1'b1);
    push(4'b0001, 4'b0, 4'b0, 8'd1, 1'b1);
    drain("stall_pre");
    stall = 1'b1; len[7:0] = 8'd1;
    push(4'b0001, 4'b0, 4'b0, 8'd1, 1'b1);
    step("stall_1");
    push(4'b0001, 4'b0, 4'b0, 8'd1, 1'b1);
    step("stall_2");
    stall = 1'b0;
    for (int i = 2; i <= 5; i++) push(4'b0001, 4'b0, 4'b0, 8'(i), 1'b1);
    push(4'b0, 4'b0001, 4'b0, 8'd5, 1'b1);
    drain("stall_post");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd5, 1'b0);
    step("stall_idle");

    // len=0
    req = 4'b0001; len[7:0] = 8'd0;
    push_run(4'b0001, 0);
    drain("len0");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd0, 1'b0);
    step("len0_idle");

    // len=255 on requester 3, no wrap
    req = 4'b1000; len[31:24] = 8'd255;
    push_run(4'b1000, 255);
    drain("len255");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd255, 1'b0);
    step("len255_idle");

    // Asynchronous reset mid-run at count=5
    req = 4'b0001; len[7:0] = 8'd10;
    for (int i = 0; i <= 5; i++) push(4'b0001, 4'b0, 4'b0, 8'(i), 1'b1);
    drain("pre_reset");
    #2 reset = 1'b1;
    req = 4'b1111; len = {4{8'd1}};
    #1;
    push(4'b0, 4'b0, 4'b0, 8'd0, 1'b0);
    check_front("async_reset");
    @(posedge clk);
    #2 reset = 1'b0;
    push_run(4'b0001, 1);
    drain("post_reset");
    req = 4'b0000;
    push(4'b0, 4'b0, 4'b0, 8'd1, 1'b0);
    step("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
